mdu: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It is the sequential companion to the single-cycle integer ALU in the EX stage of the MIPS core. It executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle, using a start/busy/done handshake. The pipeline stalls on busy and reads HI/LO directly for MFHI/MFLO.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_step.sv | 37 +++
 rtl/mdu.sv | 168 ++++++++++++++++
 tb/tb_mdu.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and small helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  // Operations that need the multi-cycle iteration.
  function automatic logic is_iter_op(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Operations whose operands are two's-complement.
  function automatic logic is_signed_op(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  // Division flavours (the rest of the iterative ops are multiplies).
  function automatic logic is_div_op(input mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the MDU datapath.
// Multiply: shift-add, multiplier in the low half, partial product in the high half.
// Divide: restoring shift-subtract, quotient grows in the low half, remainder in the high half.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Compute the next accumulator for either a multiply or a divide step.
  always_comb begin
    mul_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
            + (acc_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Remainder needs one extra bit: it is shifted before the trial subtract.
    rem_sh  = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    diff    = rem_sh - {1'b0, opnd};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_out = {mul_sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take WIDTH+1 cycles after acceptance; MTHI/MTLO complete at once.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mdu_state_t         state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  logic               op_is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               dz;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  // Operand magnitudes and signs, taken from the live inputs at acceptance.
  always_comb begin
    a_neg = is_signed_op(op) & a[WIDTH-1];
    b_neg = is_signed_op(op) & b[WIDTH-1];
    a_mag = a_neg ? ({WIDTH{1'b0}} - a) : a;
    b_mag = b_neg ? ({WIDTH{1'b0}} - b) : b;
  end

  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_in  (acc),
    .opnd    (opnd),
    .is_div  (op_is_div),
    .acc_out (acc_next)
  );

  // Final sign correction and the divide-by-zero result pattern.
  always_comb begin
    prod_neg = {(2*WIDTH){1'b0}} - acc;
    if (dz) begin
      fix_hi = a_raw;
      fix_lo = {WIDTH{1'b1}};
    end else if (op_is_div) begin
      fix_lo = neg_lo ? ({WIDTH{1'b0}} - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      fix_hi = neg_hi ? ({WIDTH{1'b0}} - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    end else if (neg_lo) begin
      fix_hi = prod_neg[2*WIDTH-1:WIDTH];
      fix_lo = prod_neg[WIDTH-1:0];
    end else begin
      fix_hi = acc[2*WIDTH-1:WIDTH];
      fix_lo = acc[WIDTH-1:0];
    end
  end

  // Control FSM, iteration state and the HI/LO/done output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= {CNT_W{1'b0}};
      acc         <= {(2*WIDTH){1'b0}};
      opnd        <= {WIDTH{1'b0}};
      a_raw       <= {WIDTH{1'b0}};
      op_is_div   <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      dz          <= 1'b0;
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            case (op)
              MDU_MULT, MDU_MULTU: begin
                acc       <= {{WIDTH{1'b0}}, b_mag};
                opnd      <= a_mag;
                a_raw     <= a;
                op_is_div <= 1'b0;
                neg_lo    <= a_neg ^ b_neg;
                neg_hi    <= a_neg ^ b_neg;
                dz        <= 1'b0;
                count     <= {CNT_W{1'b0}};
                state     <= RUN;
              end
              MDU_DIV, MDU_DIVU: begin
                acc       <= {{WIDTH{1'b0}}, a_mag};
                opnd      <= b_mag;
                a_raw     <= a;
                op_is_div <= 1'b1;
                // Quotient sign from both operands, remainder follows the dividend.
                neg_lo    <= a_neg ^ b_neg;
                neg_hi    <= a_neg;
                dz        <= (b == {WIDTH{1'b0}});
                count     <= {CNT_W{1'b0}};
                state     <= RUN;
              end
              MDU_MTHI: begin
                hi   <= a;
                done <= 1'b1;
              end
              MDU_MTLO: begin
                lo   <= a;
                done <= 1'b1;
              end
              default: begin
              end
            endcase
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc   <= acc_next;
            count <= count + CNT_W'(1);
            if (count == CNT_W'(WIDTH - 1)) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          if (!flush) begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            done        <= 1'b1;
            div_by_zero <= dz;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed, scoreboard-based bench for mdu at WIDTH=32 and WIDTH=8.
module tb_mdu;
  import mdu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  mdu_op_t     op;
  logic [31:0] a;
  logic [31:0] b;
  logic        sel8;

  logic        ready32, busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        ready8, busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  logic        m_ready, m_busy, m_done, m_dz;
  logic [31:0] m_hi, m_lo;

  exp_t        q[$];
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mdu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel8), .op(op), .a(a), .b(b),
    .flush(flush), .ready(ready32), .busy(busy32), .done(done32),
    .div_by_zero(dz32), .hi(hi32), .lo(lo32)
  );

  mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start & sel8), .op(op), .a(a[7:0]), .b(b[7:0]),
    .flush(flush), .ready(ready8), .busy(busy8), .done(done8),
    .div_by_zero(dz8), .hi(hi8), .lo(lo8)
  );

  assign m_ready = sel8 ? ready8 : ready32;
  assign m_busy  = sel8 ? busy8  : busy32;
  assign m_done  = sel8 ? done8  : done32;
  assign m_dz    = sel8 ? dz8    : dz32;
  assign m_hi    = sel8 ? {24'd0, hi8} : hi32;
  assign m_lo    = sel8 ? {24'd0, lo8} : lo32;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour using native arithmetic on sign-extended values.
  function automatic exp_t model(input int w, input mdu_op_t o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint unsigned mask, ux, uy, up;
    longint sx, sy, p, qv, rv;
    mask = (64'd1 << w) - 64'd1;
    ux = 64'(x) & mask;
    uy = 64'(y) & mask;
    sx = x[w-1] ? longint'(ux) - (longint'(1) << w) : longint'(ux);
    sy = y[w-1] ? longint'(uy) - (longint'(1) << w) : longint'(uy);
    e.hi = exp_hi; e.lo = exp_lo; e.dz = 1'b0; e.lat = w + 2; e.tag = "";
    case (o)
      MDU_MULT: begin
        p = sx * sy;
        e.hi = 32'((p >>> w) & mask);
        e.lo = 32'(p & mask);
      end
      MDU_MULTU: begin
        up = ux * uy;
        e.hi = 32'((up >> w) & mask);
        e.lo = 32'(up & mask);
      end
      MDU_DIV, MDU_DIVU: begin
        if (uy == 64'd0) begin
          e.hi = 32'(ux); e.lo = 32'(mask); e.dz = 1'b1;
        end else if (o == MDU_DIV) begin
          qv = sx / sy; rv = sx % sy;
          e.hi = 32'(rv & mask); e.lo = 32'(qv & mask);
        end else begin
          e.hi = 32'((ux % uy) & mask); e.lo = 32'((ux / uy) & mask);
        end
      end
      MDU_MTHI: begin e.hi = 32'(ux); e.lat = 1; end
      MDU_MTLO: begin e.lo = 32'(ux); e.lat = 1; end
      default: begin end
    endcase
    return e;
  endfunction

  // Called at a negedge; drives a one-cycle start and returns at the next negedge.
  task automatic issue(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y,
                       input bit push, input string tag);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    if (push) begin
      e = model(sel8 ? 8 : 32, o, x, y);
      e.tag = tag;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    if (is_iter_op(o)) check({tag, "_busy1"}, 64'(m_busy), 64'd1);
  endtask

  // Waits for done (bounded), then pops the scoreboard and compares everything.
  task automatic wait_done(input int n0);
    exp_t e;
    int n = n0;
    int busy_cnt = 0;
    while (m_done !== 1'b1 && n < 200) begin
      if (m_busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check("sb_nonempty", 64'(q.size() != 0), 64'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      check({e.tag, "_lat"},   64'(n),        64'(e.lat));
      check({e.tag, "_busyn"}, 64'(busy_cnt), 64'(e.lat - n0));
      check({e.tag, "_done"},  64'(m_done),   64'd1);
      check({e.tag, "_hi"},    64'(m_hi),     64'(e.hi));
      check({e.tag, "_lo"},    64'(m_lo),     64'(e.lo));
      check({e.tag, "_dz"},    64'(m_dz),     64'(e.dz));
      check({e.tag, "_ready"}, 64'(m_ready),  64'd1);
      exp_hi = e.hi;
      exp_lo = e.lo;
    end
  endtask

  // Watches a window where no completion may occur and HI/LO must hold.
  task automatic expect_quiet(input string tag, input int cycles);
    int dn = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (m_done === 1'b1) dn++;
    end
    check({tag, "_nodone"}, 64'(dn),   64'd0);
    check({tag, "_hi"},     64'(m_hi), 64'(exp_hi));
    check({tag, "_lo"},     64'(m_lo), 64'(exp_lo));
  endtask

  task automatic run_basic(input string pfx);
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, {pfx, "mult"});
    wait_done(1);
    @(negedge clk);
    check({pfx, "mult_done_drop"}, 64'(m_done), 64'd0);
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, {pfx, "multu"});
    wait_done(1);
    // Back-to-back: issued in the done cycle.
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, {pfx, "div_b2b"});
    wait_done(1);
    @(negedge clk);
    issue(MDU_DIVU, 32'd100, 32'd0, 1'b1, {pfx, "divu_dz"});
    wait_done(1);
    @(negedge clk);
    check({pfx, "dz_drop"}, 64'(m_dz), 64'd0);
    check({pfx, "dz_done_drop"}, 64'(m_done), 64'd0);
    issue(MDU_DIV, sel8 ? 32'h0000_0080 : 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {pfx, "div_ovf"});
    wait_done(1);
    @(negedge clk);
    issue(MDU_DIV, 32'd1000, 32'hFFFF_FFF9, 1'b1, {pfx, "div_mix"});
    wait_done(1);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = MDU_MULT;
    a = 32'd0; b = 32'd0; sel8 = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state of both instances.
    for (int s = 0; s < 2; s++) begin
      sel8 = (s == 1);
      #1;
      check("rst_hi",    64'(m_hi),    64'd0);
      check("rst_lo",    64'(m_lo),    64'd0);
      check("rst_ready", 64'(m_ready), 64'd1);
      check("rst_busy",  64'(m_busy),  64'd0);
      check("rst_done",  64'(m_done),  64'd0);
      check("rst_dz",    64'(m_dz),    64'd0);
    end
    sel8 = 1'b0;
    @(negedge clk);

    run_basic("w32_");

    // start while busy is ignored.
    issue(MDU_MULT, 32'd12345, 32'hFFFF_FD5A, 1'b1, "mult_ign");
    repeat (3) @(negedge clk);
    start = 1'b1; op = MDU_DIVU; a = 32'd77; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(5);
    @(negedge clk);

    // MTHI / MTLO complete immediately, other register unchanged.
    issue(MDU_MTHI, 32'h0000_1234, 32'd0, 1'b1, "mthi");
    wait_done(1);
    @(negedge clk);
    check("mthi_done_drop", 64'(m_done), 64'd0);
    issue(MDU_MTLO, 32'hCAFE_F00D, 32'd0, 1'b1, "mtlo");
    wait_done(1);
    @(negedge clk);

    // Invalid opcode is ignored.
    issue(mdu_op_t'(3'd6), 32'h5555_5555, 32'd1, 1'b0, "inval");
    check("inval_ready", 64'(m_ready), 64'd1);
    expect_quiet("inval", 5);

    // Flush mid-divide.
    issue(MDU_DIV, 32'd1000, 32'd7, 1'b0, "flush_div");
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", 64'(m_ready), 64'd1);
    expect_quiet("flush", 40);

    // Flush coincident with start in IDLE.
    start = 1'b1; flush = 1'b1; op = MDU_MTHI; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("fs_mthi_done", 64'(m_done), 64'd0);
    check("fs_mthi_hi",   64'(m_hi),   64'(exp_hi));
    start = 1'b1; flush = 1'b1; op = MDU_MULT; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("fs_mult_ready", 64'(m_ready), 64'd1);
    expect_quiet("fs_mult", 40);

    // Reset during RUN with HI/LO nonzero.
    issue(MDU_MULT, 32'd3, 32'd4, 1'b0, "rst_run");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    check("rstrun_hi",    64'(m_hi),    64'd0);
    check("rstrun_lo",    64'(m_lo),    64'd0);
    check("rstrun_ready", 64'(m_ready), 64'd1);
    check("rstrun_done",  64'(m_done),  64'd0);
    expect_quiet("rstrun", 40);

    // Same basic set on the 8-bit instance.
    sel8 = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
    run_basic("w8_");

    check("sb_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
